// File: rtl/binary_game_round_ctrl.sv
// Round sequencer for the binary-number game in Play mode.
// Latches a random target each round, runs a per-round countdown, judges
// player submissions and tracks score, lives and the session high score.
// All outputs are registers or direct decodes of the state register.
module binary_game_round_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned ROUND_SECS    = 10,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Submit,
    input  logic               Quit,
    input  logic [7:0]         randNumber,
    input  logic [7:0]         userNumber,
    output logic [7:0]         targetNumber,
    output logic [3:0]         timeLeft,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] highScore,
    output logic               correct,
    output logic               wrong,
    output logic               gameOver,
    output logic [2:0]         stateOut
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_JUDGE = 3'd3;
    localparam logic [2:0] S_HIT   = 3'd4;
    localparam logic [2:0] S_MISS  = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    // A one-tick second still needs a 1-bit counter that is always at its last value.
    localparam int unsigned        TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]         ROUND_INIT = 4'(ROUND_SECS);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [TICK_W-1:0]  r_tick;
    logic [7:0]         r_target;
    logic [7:0]         r_user;
    logic [3:0]         r_time;
    logic [2:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic               w_wrap;
    logic               w_timeout;
    logic               w_enter_over;

    assign w_wrap       = (r_tick == TICK_LAST);
    assign w_timeout    = w_wrap && (r_time == 4'd1);
    assign w_enter_over = (w_state_nxt == S_OVER) && (r_state != S_OVER);

    // Next-state selection; Quit beats Submit beats timeout in PLAY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (Quit)           w_state_nxt = S_OVER;
                else if (Submit)    w_state_nxt = S_JUDGE;
                else if (w_timeout) w_state_nxt = S_MISS;
            end
            S_JUDGE: w_state_nxt = (r_user == r_target) ? S_HIT : S_MISS;
            S_HIT:   w_state_nxt = S_LOAD;
            S_MISS:  w_state_nxt = (r_lives == 3'd1) ? S_OVER : S_LOAD;
            S_OVER:  if (Start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and round datapath, with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_target <= 8'd0;
            r_user   <= 8'd0;
            r_time   <= 4'd0;
            r_lives  <= 3'd0;
            r_score  <= '0;
            r_high   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (Start) begin
                        r_score <= '0;
                        r_lives <= LIVES_INIT;
                    end
                end
                S_LOAD: begin
                    r_target <= randNumber;
                    r_time   <= ROUND_INIT;
                    r_tick   <= '0;
                end
                S_PLAY: begin
                    r_tick <= w_wrap ? '0 : r_tick + 1'b1;
                    if (w_wrap && (r_time != 4'd0)) begin
                        r_time <= r_time - 4'd1;
                    end
                    if (Submit && !Quit) begin
                        r_user <= userNumber;
                    end
                end
                S_HIT: begin
                    if (r_score != SCORE_MAX) begin
                        r_score <= r_score + 1'b1;
                    end
                end
                S_MISS: r_lives <= r_lives - 3'd1;
                default: ;
            endcase
            // Score never changes on an edge that enters OVER, so r_score is already final.
            if (w_enter_over && (r_score > r_high)) begin
                r_high <= r_score;
            end
        end
    end

    assign targetNumber = r_target;
    assign timeLeft     = r_time;
    assign lives        = r_lives;
    assign score        = r_score;
    assign highScore    = r_high;
    assign correct      = (r_state == S_HIT);
    assign wrong        = (r_state == S_MISS);
    assign gameOver     = (r_state == S_OVER);
    assign stateOut     = r_state;

endmodule

// File: tb/tb_binary_game_round_ctrl.sv
// Bench for binary_game_round_ctrl: directed stimulus, a game-rules model
// compared every cycle, and literal expectations at key points.
module tb_binary_game_round_ctrl;

    localparam int unsigned T = 4;
    localparam int unsigned R = 3;
    localparam int unsigned L = 2;
    localparam int unsigned SW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Submit = 1'b0;
    logic          Quit = 1'b0;
    logic [7:0]    randNumber = 8'd0;
    logic [7:0]    userNumber = 8'd0;
    logic [7:0]    targetNumber;
    logic [3:0]    timeLeft;
    logic [2:0]    lives;
    logic [SW-1:0] score;
    logic [SW-1:0] highScore;
    logic          correct;
    logic          wrong;
    logic          gameOver;
    logic [2:0]    stateOut;

    int n_vec = 0;
    int n_bad = 0;

    binary_game_round_ctrl #(
        .TICKS_PER_SEC(T),
        .ROUND_SECS   (R),
        .LIVES        (L),
        .SCORE_W      (SW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Submit      (Submit),
        .Quit        (Quit),
        .randNumber  (randNumber),
        .userNumber  (userNumber),
        .targetNumber(targetNumber),
        .timeLeft    (timeLeft),
        .lives       (lives),
        .score       (score),
        .highScore   (highScore),
        .correct     (correct),
        .wrong       (wrong),
        .gameOver    (gameOver),
        .stateOut    (stateOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Game-rules model: phase code, elapsed PLAY cycles, and game variables.
    int       m_st = 0;
    int       m_pc = 0;
    bit       m_loaded = 1'b0;
    int       m_target = 0;
    int       m_user = 0;
    int       m_lives = 0;
    int       m_score = 0;
    int       m_high = 0;

    always @(posedge Clk) begin : model
        int st, pc, tg, us, lv, sc, hi;
        bit ld;
        st = m_st; pc = m_pc; tg = m_target; us = m_user;
        lv = m_lives; sc = m_score; hi = m_high; ld = m_loaded;
        if (Reset) begin
            st = 0; pc = 0; tg = 0; us = 0; lv = 0; sc = 0; hi = 0; ld = 1'b0;
        end else begin
            case (m_st)
                0, 6: if (Start) begin st = 1; sc = 0; lv = L; end
                1: begin tg = randNumber; pc = 0; ld = 1'b1; st = 2; end
                2: begin
                    pc = m_pc + 1;
                    if (Quit) begin
                        st = 6;
                        hi = (sc > hi) ? sc : hi;
                    end else if (Submit) begin
                        st = 3; us = userNumber;
                    end else if (pc == R * T) begin
                        st = 5;
                    end
                end
                3: st = (m_user == m_target) ? 4 : 5;
                4: begin sc = (sc < (1 << SW) - 1) ? sc + 1 : sc; st = 1; end
                5: begin
                    lv = m_lives - 1;
                    if (m_lives == 1) begin
                        st = 6;
                        hi = (sc > hi) ? sc : hi;
                    end else begin
                        st = 1;
                    end
                end
                default: st = 0;
            endcase
        end
        m_st <= st; m_pc <= pc; m_target <= tg; m_user <= us;
        m_lives <= lv; m_score <= sc; m_high <= hi; m_loaded <= ld;
    end

    function automatic int model_time();
        int t;
        if (!m_loaded) return 0;
        t = int'(R) - m_pc / int'(T);
        return (t < 0) ? 0 : t;
    endfunction

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge Clk) begin
        #1;
        check("stateOut", 32'(stateOut), 32'(m_st));
        check("targetNumber", 32'(targetNumber), 32'(m_target));
        check("timeLeft", 32'(timeLeft), 32'(model_time()));
        check("lives", 32'(lives), 32'(m_lives));
        check("score", 32'(score), 32'(m_score));
        check("highScore", 32'(highScore), 32'(m_high));
        check("correct", 32'(correct), 32'(m_st == 4));
        check("wrong", 32'(wrong), 32'(m_st == 5));
        check("gameOver", 32'(gameOver), 32'(m_st == 6));
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        step(2);
        Reset = 1'b0;
        check("pin reset state", 32'(stateOut), 32'd0);
        check("pin reset score", 32'(score), 32'd0);
        check("pin reset lives", 32'(lives), 32'd0);

        // Submit in IDLE is ignored.
        Submit = 1'b1; userNumber = 8'h11;
        step(1);
        Submit = 1'b0;
        check("pin idle ignores submit", 32'(stateOut), 32'd0);

        // Start, target latched in LOAD.
        Start = 1'b1; randNumber = 8'hA5;
        step(1);
        Start = 1'b0;
        check("pin load state", 32'(stateOut), 32'd1);
        step(1);
        check("pin play state", 32'(stateOut), 32'd2);
        check("pin target A5", 32'(targetNumber), 32'hA5);
        check("pin time 3", 32'(timeLeft), 32'd3);
        check("pin lives 2", 32'(lives), 32'd2);
        check("pin score 0", 32'(score), 32'd0);

        // Start mid-round is ignored.
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        check("pin start ignored", 32'(stateOut), 32'd2);

        // Correct submission.
        Submit = 1'b1; userNumber = 8'hA5; randNumber = 8'h3C;
        step(1);
        Submit = 1'b0;
        check("pin judge", 32'(stateOut), 32'd3);
        step(1);
        check("pin hit correct", 32'(correct), 32'd1);
        check("pin hit wrong", 32'(wrong), 32'd0);
        step(1);
        check("pin correct one cycle", 32'(correct), 32'd0);
        check("pin score 1", 32'(score), 32'd1);
        step(1);
        check("pin target 3C", 32'(targetNumber), 32'h3C);
        check("pin new time 3", 32'(timeLeft), 32'd3);

        // Timeout: 12 PLAY cycles.
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (i == 4) check("pin time 2", 32'(timeLeft), 32'd2);
            if (i == 8) check("pin time 1", 32'(timeLeft), 32'd1);
            if (i == 11) check("pin still play", 32'(stateOut), 32'd2);
        end
        check("pin timeout miss", 32'(wrong), 32'd1);
        check("pin timeout time 0", 32'(timeLeft), 32'd0);
        step(1);
        check("pin wrong one cycle", 32'(wrong), 32'd0);
        check("pin lives 1", 32'(lives), 32'd1);
        step(1);
        check("pin replay time 3", 32'(timeLeft), 32'd3);

        // Last life lost on a wrong answer.
        Submit = 1'b1; userNumber = 8'h00;
        step(1);
        Submit = 1'b0;
        step(1);
        check("pin miss wrong", 32'(wrong), 32'd1);
        step(1);
        check("pin over gameOver", 32'(gameOver), 32'd1);
        check("pin over lives 0", 32'(lives), 32'd0);
        check("pin over high 1", 32'(highScore), 32'd1);
        step(3);
        check("pin over holds target", 32'(targetNumber), 32'h3C);

        // Restart from OVER, score one point, then Quit+Submit together.
        randNumber = 8'h5A; Start = 1'b1;
        step(1);
        Start = 1'b0;
        check("pin restart score", 32'(score), 32'd0);
        check("pin restart lives", 32'(lives), 32'd2);
        check("pin restart high", 32'(highScore), 32'd1);
        step(1);
        Submit = 1'b1; userNumber = 8'h5A;
        step(1);
        Submit = 1'b0;
        step(3);
        check("pin second score 1", 32'(score), 32'd1);
        Quit = 1'b1; Submit = 1'b1; userNumber = 8'h5A;
        step(1);
        Quit = 1'b0; Submit = 1'b0;
        check("pin quit over", 32'(stateOut), 32'd6);
        check("pin quit no correct", 32'(correct), 32'd0);
        check("pin quit score", 32'(score), 32'd1);
        step(1);
        check("pin quit no judge", 32'(stateOut), 32'd6);
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        check("pin restart2 score", 32'(score), 32'd0);
        check("pin restart2 high", 32'(highScore), 32'd1);
        step(1);

        // Reset mid-round overrides Submit.
        Reset = 1'b1; Submit = 1'b1; userNumber = 8'h5A;
        step(1);
        Reset = 1'b0; Submit = 1'b0;
        check("pin reset mid state", 32'(stateOut), 32'd0);
        check("pin reset mid high", 32'(highScore), 32'd0);
        check("pin reset mid correct", 32'(correct), 32'd0);
        check("pin reset mid wrong", 32'(wrong), 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
